// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// Shared defaults and state type for the serial-port transmit drain controller.
// The FIFO sizing defaults live here so that syn_fifo and this controller stay in step.
package uart_tx_fifo_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_BAUD_DIV   = 16;
  localparam int DEF_DIV_WIDTH  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// FIFO read port plus serial-line outputs of the transmit drain controller.
// The controller side is the master; the FIFO/pin environment is the slave.
interface uart_tx_fifo_ctrl_if
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  tx_en;
  logic                  fifo_is_empty;
  logic [DATA_WIDTH-1:0] fifo_r_data;
  logic                  fifo_r_en;
  logic                  txd;
  logic                  busy;
  logic                  tx_done;

  modport master (
    input  tx_en, fifo_is_empty, fifo_r_data,
    output fifo_r_en, txd, busy, tx_done
  );

  modport slave (
    output tx_en, fifo_is_empty, fifo_r_data,
    input  fifo_r_en, txd, busy, tx_done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the last count
// of each bit so the FSM can advance exactly on bit boundaries.
module uart_baud_cnt
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int BAUD_DIV  = DEF_BAUD_DIV,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(BAUD_DIV - 1);

  logic [DIV_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Drains the transmit FIFO one byte at a time and shifts each byte out on txd as 8N1.
// This block is the only agent allowed to pop the FIFO.
module uart_tx_fifo_ctrl
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BAUD_DIV   = DEF_BAUD_DIV,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  uart_tx_fifo_ctrl_if.master bus
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  tx_state_t             next_state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  baud_clr;
  logic                  baud_en;
  logic                  bit_tick;
  logic                  r_en;
  logic                  txd;
  logic                  busy;
  logic                  tx_done;
  logic                  can_pop;

  uart_baud_cnt #(
    .BAUD_DIV  (BAUD_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (baud_clr),
    .en       (baud_en),
    .bit_tick (bit_tick)
  );

  assign can_pop = bus.tx_en && !bus.fifo_is_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs depend only on state, the shift register and the baud tick, never on inputs.
  always_comb begin
    next_state = state;
    r_en       = 1'b0;
    txd        = 1'b1;
    busy       = 1'b1;
    tx_done    = 1'b0;
    baud_clr   = 1'b0;
    baud_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (can_pop) next_state = ST_POP;
      end
      ST_POP: begin
        r_en       = 1'b1;
        next_state = ST_LATCH;
      end
      ST_LATCH: begin
        baud_clr   = 1'b1;
        next_state = ST_START;
      end
      ST_START: begin
        txd     = 1'b0;
        baud_en = 1'b1;
        if (bit_tick) next_state = ST_DATA;
      end
      ST_DATA: begin
        txd     = shift_q[0];
        baud_en = 1'b1;
        if (bit_tick && (bit_cnt == LAST_BIT)) next_state = ST_STOP;
      end
      ST_STOP: begin
        baud_en = 1'b1;
        tx_done = bit_tick;
        if (bit_tick) next_state = can_pop ? ST_POP : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_LATCH: begin
          shift_q <= bus.fifo_r_data;
          bit_cnt <= '0;
        end
        ST_START: begin
          if (bit_tick) bit_cnt <= '0;
        end
        ST_DATA: begin
          if (bit_tick) begin
            shift_q <= shift_q >> 1;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_r_en = r_en;
  assign bus.txd       = txd;
  assign bus.busy      = busy;
  assign bus.tx_done   = tx_done;

endmodule
